mmio_bridge: RTL and testbench

Memory-mapped I/O bridge between the CPU's port-A memory interface and the dual-port RAM. It splits a parametrised 16-word I/O window off the top of the address space. Inside that window it provides writable output registers, synchronised and debounced input ports, sticky change flags and a free-running cycle counter, so programs can drive displays and LEDs and read switches through ordinary load/store. Addresses outside the window pass through to RAM unchanged.

---
 rtl/mmio_bridge.sv | 147 ++++++++++++++
 tb/tb_mmio_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: splits a 16-word I/O window off the top of the CPU address
// space. Inside the window it provides output registers, synchronised and
// debounced inputs, sticky change flags and a free-running cycle counter.
// All other addresses pass straight through to the RAM.
module mmio_bridge #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] IO_BASE  = 10'h3F0,
  parameter int                NUM_OUT  = 4,
  parameter int                NUM_IN   = 2,
  parameter int                DEBOUNCE = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic                      cpu_we,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic [NUM_OUT*DATA_W-1:0] out_regs,
  input  logic [NUM_IN*DATA_W-1:0]  in_raw,
  output logic                      irq_change
);

  // Debounce counter only ever needs to reach DEBOUNCE-1.
  localparam int            CW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);

  logic              io_hit;
  logic [3:0]        off;
  logic              wr;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] out_q  [NUM_OUT];
  logic [DATA_W-1:0] sync_a [NUM_IN];
  logic [DATA_W-1:0] s      [NUM_IN];
  logic [DATA_W-1:0] s_prev [NUM_IN];
  logic [DATA_W-1:0] d      [NUM_IN];
  logic [CW-1:0]     c      [NUM_IN];
  logic [CW-1:0]     run    [NUM_IN];
  logic [NUM_IN-1:0] acc;
  logic [NUM_IN-1:0] clr;
  logic [NUM_IN-1:0] flags;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] io_q;
  logic              sel;

  assign io_hit     = (cpu_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
  assign off        = cpu_addr[3:0];
  assign wr         = cpu_we & io_hit;
  assign ram_addr   = cpu_addr;
  assign ram_wdata  = cpu_wdata;
  assign ram_we     = cpu_we & ~io_hit;
  assign irq_change = |flags;
  assign cpu_rdata  = sel ? io_q : ram_rdata;
  assign clr        = (wr && off == 4'hE) ? cpu_wdata[NUM_IN-1:0] : '0;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[g*DATA_W +: DATA_W] = out_q[g];
  end

  // Read mux for the I/O window; unmapped offsets read zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (off == 4'(i)) rd_val = out_q[i];
    for (int i = 0; i < NUM_IN; i++)
      if (off == 4'(8 + i)) rd_val = d[i];
    if (off == 4'hE) rd_val = DATA_W'(flags);
    if (off == 4'hF) rd_val = cnt;
  end

  // Stable-run length per input: the cycle in which s changes counts as the
  // first stable cycle, so acceptance lands DEBOUNCE edges after the change.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      run[i] = (s[i] != s_prev[i]) ? '0 : c[i];
      acc[i] = (s[i] != d[i]) && (run[i] == C_LAST);
    end
  end

  // Input synchronisers, debounce counters and accepted values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync_a[i] <= '0;
        s[i]      <= '0;
        s_prev[i] <= '0;
        d[i]      <= '0;
        c[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync_a[i] <= in_raw[i*DATA_W +: DATA_W];
        s[i]      <= sync_a[i];
        s_prev[i] <= s[i];
        if (s[i] == d[i]) begin
          c[i] <= '0;
        end else if (acc[i]) begin
          d[i] <= s[i];
          c[i] <= '0;
        end else begin
          c[i] <= run[i] + 1'b1;
        end
      end
    end
  end

  // Sticky change flags: a new acceptance beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= (flags & ~clr) | acc;
  end

  // Free-running cycle counter; a store overrides the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (wr && off == 4'hF)  cnt <= cpu_wdata;
    else                         cnt <= cnt + 1'b1;
  end

  // Writable output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (wr && off == 4'(i)) out_q[i] <= cpu_wdata;
    end
  end

  // Read-select stage: captures the pre-write value so read-during-write
  // returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel  <= 1'b0;
      io_q <= '0;
    end else begin
      sel <= io_hit;
      if (io_hit) io_q <= rd_val;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Testbench for mmio_bridge: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_mmio_bridge;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NO = 4;
  localparam int NI = 2;
  localparam int DB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [AW-1:0]  cpu_addr;
  logic [DW-1:0]  cpu_wdata;
  logic           cpu_we;
  logic [DW-1:0]  cpu_rdata;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_wdata;
  logic           ram_we;
  logic [DW-1:0]  ram_rdata;
  logic [NO*DW-1:0] out_regs;
  logic [NI*DW-1:0] in_raw;
  logic           irq_change;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  mmio_bridge #(
    .DATA_W(DW), .ADDR_W(AW), .IO_BASE(10'h3F0),
    .NUM_OUT(NO), .NUM_IN(NI), .DEBOUNCE(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .out_regs(out_regs), .in_raw(in_raw), .irq_change(irq_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_out [NO];
  logic [DW-1:0] m_sync [NI];
  logic [DW-1:0] m_s [NI];
  logic [DW-1:0] m_d [NI];
  int            m_run [NI];   // cycles s has held its value, this one included
  logic [NI-1:0] m_flag;
  logic [DW-1:0] m_cnt;
  logic          m_sel;
  logic [DW-1:0] m_q;

  function automatic logic [DW-1:0] m_read(input logic [3:0] o);
    int k;
    k = int'(o);
    if (k < NO) return m_out[k];
    if (k >= 8 && k < 8 + NI) return m_d[k-8];
    if (k == 14) return DW'(m_flag);
    if (k == 15) return m_cnt;
    return '0;
  endfunction

  logic          mh;
  logic [3:0]    mo;
  logic [DW-1:0] mrv;
  logic [NI-1:0] macc;
  logic [NI-1:0] mclr;
  logic [DW-1:0] mns;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NO; i++) m_out[i] = '0;
      for (int i = 0; i < NI; i++) begin
        m_sync[i] = '0; m_s[i] = '0; m_d[i] = '0; m_run[i] = 1;
      end
      m_flag = '0; m_cnt = '0; m_sel = 1'b0; m_q = '0;
    end else begin
      mh  = (cpu_addr[AW-1:4] == 6'h3F);
      mo  = cpu_addr[3:0];
      mrv = m_read(mo);
      for (int i = 0; i < NI; i++)
        macc[i] = (m_s[i] != m_d[i]) && (m_run[i] == DB);
      mclr = '0;
      if (mh && cpu_we) begin
        if (int'(mo) < NO) m_out[int'(mo)] = cpu_wdata;
        if (mo == 4'd14) mclr = cpu_wdata[NI-1:0];
      end
      m_flag = (m_flag & ~mclr) | macc;
      m_cnt = (mh && cpu_we && mo == 4'd15) ? cpu_wdata : DW'(m_cnt + 1);
      for (int i = 0; i < NI; i++) begin
        if (macc[i]) m_d[i] = m_s[i];
        mns = m_sync[i];
        if (mns == m_s[i]) m_run[i] = (m_run[i] > DB) ? m_run[i] : m_run[i] + 1;
        else               m_run[i] = 1;
        m_s[i] = mns;
        m_sync[i] = in_raw[i*DW +: DW];
      end
      m_sel = mh;
      if (mh) m_q = mrv;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out_regs", out_regs, {m_out[3], m_out[2], m_out[1], m_out[0]});
      check("irq_change", irq_change, |m_flag);
      check("cpu_rdata", cpu_rdata, m_sel ? m_q : ram_rdata);
      check("ram_we", ram_we, cpu_we && (cpu_addr[AW-1:4] != 6'h3F));
      check("ram_addr", ram_addr, cpu_addr);
      check("ram_wdata", ram_wdata, cpu_wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_we   = 1'b0;
    cpu_addr = 10'h005;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] v);
    cpu_addr  = a;
    cpu_wdata = v;
    cpu_we    = 1'b1;
    tick();
    idle();
  endtask

  task automatic load(input logic [AW-1:0] a, output logic [DW-1:0] v);
    cpu_addr = a;
    cpu_we   = 1'b0;
    tick();
    v = cpu_rdata;
    idle();
  endtask

  logic [DW-1:0]    rv;
  logic [NO*DW-1:0] snap;

  initial begin
    cpu_addr  = 10'h005;
    cpu_wdata = '0;
    cpu_we    = 1'b0;
    ram_rdata = 16'h5A5A;
    in_raw    = '0;
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_out_regs", out_regs, 64'h0);
    check("rst_irq", irq_change, 1'b0);
    check("rst_rdata_ram", cpu_rdata, 16'h5A5A);
    load(10'h3FF, rv);
    check("rst_counter", rv, 16'h0000);

    // Store / load through the window
    cpu_addr = 10'h3F1; cpu_wdata = 16'hBEEF; cpu_we = 1'b1;
    #1 check("store_ram_we", ram_we, 1'b0);
    tick();
    idle();
    check("store_out1", out_regs[31:16], 16'hBEEF);
    load(10'h3F1, rv);
    check("load_out1", rv, 16'hBEEF);
    load(10'h005, rv);
    check("load_ram", rv, 16'h5A5A);

    // Held input accepted after 2 + DEBOUNCE edges
    in_raw[15:0] = 16'h00A5;
    repeat (5) tick();
    check("deb_irq_early", irq_change, 1'b0);
    tick();
    check("deb_irq_set", irq_change, 1'b1);
    load(10'h3F8, rv);
    check("deb_in0", rv, 16'h00A5);
    load(10'h3FE, rv);
    check("deb_flags", rv, 16'h0001);

    // Short pulse on port 1 must never be accepted
    in_raw[31:16] = 16'h0001;
    repeat (3) tick();
    in_raw[31:16] = 16'h0000;
    repeat (10) tick();
    load(10'h3F9, rv);
    check("pulse_in1", rv, 16'h0000);
    load(10'h3FE, rv);
    check("pulse_flags", rv, 16'h0001);

    // Flag set beats a same-edge clear
    in_raw[15:0] = 16'h005A;
    repeat (5) tick();
    store(10'h3FE, 16'h0001);
    check("setwins_irq", irq_change, 1'b1);
    load(10'h3FE, rv);
    check("setwins_flags", rv, 16'h0001);
    load(10'h3F8, rv);
    check("setwins_in0", rv, 16'h005A);
    store(10'h3FE, 16'h0001);
    check("clear_irq", irq_change, 1'b0);

    // Counter load and wrap
    store(10'h3FF, 16'hFFFE);
    repeat (3) tick();
    load(10'h3FF, rv);
    check("cnt_wrap", rv, 16'h0001);

    // Unmapped offset
    snap = out_regs;
    store(10'h3FA, 16'h1234);
    check("unmapped_out", out_regs, snap);
    load(10'h3FA, rv);
    check("unmapped_read", rv, 16'h0000);
    load(10'h3FE, rv);
    check("unmapped_flags", rv, 16'h0000);

    // Asynchronous reset mid-debounce
    in_raw[15:0] = 16'h0000;
    repeat (6) tick();
    check("pre_rst_irq", irq_change, 1'b1);
    store(10'h3F0, 16'h1234);
    check("pre_rst_out0", out_regs[15:0], 16'h1234);
    in_raw[31:16] = 16'h00F0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("async_rst_out", out_regs, 64'h0);
    check("async_rst_irq", irq_change, 1'b0);
    check("async_rst_rdata", cpu_rdata, ram_rdata);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_irq_early", irq_change, 1'b0);
    tick();
    check("post_rst_irq_set", irq_change, 1'b1);
    load(10'h3F9, rv);
    check("post_rst_in1", rv, 16'h00F0);

    // Randomized traffic checked by the model
    repeat (3000) begin
      if ($urandom_range(1, 0) == 1) cpu_addr = {6'h3F, 4'($urandom_range(15, 0))};
      else                           cpu_addr = 10'($urandom);
      cpu_we    = ($urandom_range(3, 0) == 0);
      cpu_wdata = 16'($urandom);
      ram_rdata = 16'($urandom);
      if ($urandom_range(9, 0) == 0) begin
        if ($urandom_range(1, 0) == 1) in_raw[31:16] = 16'($urandom_range(7, 0));
        else                           in_raw[15:0]  = 16'($urandom_range(7, 0));
      end
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
